// File: rtl/imm_pkg.sv
// imm_pkg: shared widths, extension modes and FSM encoding for the immediate arbiter
package imm_pkg;
    localparam int IMM_W  = 8;
    localparam int WORD_W = 16;

    localparam logic [1:0] MODE_SEXT  = 2'b00;
    localparam logic [1:0] MODE_ZEXT  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXTEND = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
endpackage

// File: rtl/sign_extender.sv
// sign_extender: replicates the immediate's top bit into the upper half of the word
module sign_extender
    import imm_pkg::*;
(
    input  logic [IMM_W-1:0]  din,
    output logic [WORD_W-1:0] dout
);
    assign dout = {{(WORD_W - IMM_W){din[IMM_W-1]}}, din};
endmodule

// File: rtl/imm_arbiter.sv
// imm_arbiter: round-robin sharing of one sign_extender among NREQ requesters,
// with a registered, tagged response held until the consumer accepts it.
module imm_arbiter
    import imm_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*IMM_W-1:0]  imm,
    input  logic [NREQ*2-1:0]      mode,
    output logic [NREQ-1:0]        gnt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_id,
    output logic [WORD_W-1:0]      result,
    output logic                   busy
);
    logic [1:0]          state;
    logic [1:0]          ptr;
    logic [1:0]          win;
    logic                found;
    logic [1:0]          lat_id;
    logic [1:0]          lat_mode;
    logic [IMM_W-1:0]    lat_imm;
    logic [WORD_W-1:0]   sext;
    logic [WORD_W-1:0]   ext;
    logic [3:0]          req_x;
    logic [4*IMM_W-1:0]  imm_x;
    logic [7:0]          mode_x;

    // Returns {found, index}: the first requester at or after p, wrapping at NREQ.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] pick;
        logic [1:0] j;
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = 2'((int'(p) + k) % NREQ);
            if (r[j]) pick = {1'b1, j};
        end
        return pick;
    endfunction

    // Widen the requester buses to four slots so a 2-bit index is always in range.
    assign req_x  = 4'(req);
    assign imm_x  = (4 * IMM_W)'(imm);
    assign mode_x = 8'(mode);

    assign {found, win} = rr_pick(req_x, ptr);

    for (genvar i = 0; i < NREQ; i++) begin : g_gnt
        assign gnt[i] = (state == ST_IDLE) && found && (win == 2'(i));
    end

    assign busy = state != ST_IDLE;

    sign_extender u_sext (
        .din  (lat_imm),
        .dout (sext)
    );

    assign ext = lat_mode == MODE_ZEXT  ? {8'h00, lat_imm} :
                 lat_mode == MODE_UPPER ? {lat_imm, 8'h00} : sext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            lat_id    <= '0;
            lat_imm   <= '0;
            lat_mode  <= MODE_SEXT;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            result    <= '0;
        end else if (state == ST_IDLE && found) begin
            lat_id   <= win;
            lat_imm  <= imm_x[win*IMM_W +: IMM_W];
            lat_mode <= mode_x[win*2 +: 2];
            ptr      <= win == 2'(NREQ - 1) ? 2'd0 : win + 2'd1;
            state    <= ST_EXTEND;
        end else if (state == ST_EXTEND) begin
            result    <= ext;
            rsp_id    <= lat_id;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
        end else if (state == ST_RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
        end else if (state != ST_IDLE && state != ST_RESP) begin
            state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_imm_arbiter.sv
// tb_imm_arbiter: randomized and directed stimulus against a queue-based
// round-robin reference, with a separate response monitor.
module tb_imm_arbiter;
    localparam int N = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*8-1:0]  imm = '0;
    logic [N*2-1:0]  mode = '0;
    logic            rsp_ready = 1'b1;
    logic [N-1:0]    gnt;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [15:0]     result;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] res;
        int          due;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int           ptr_m = 0;
    int           j;
    int           w;
    bit           in_flight = 0;
    bit           clear_next = 0;
    bit           holding = 0;
    logic [N-1:0] gseen = '0;
    logic [N-1:0] exp_g;
    logic [1:0]   held_id;
    logic [15:0]  held_res;

    imm_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .imm       (imm),
        .mode      (mode),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_ext(input logic [7:0] v, input logic [1:0] m);
        if (m == 2'd1) return 16'(v);
        if (m == 2'd2) return 16'(v) * 16'd256;
        return v >= 8'd128 ? 16'(v) + 16'hFF00 : 16'(v);
    endfunction

    // Grant model: round-robin over requesters while no transaction is in flight.
    always @(negedge clk) begin
        if (reset) begin
            ptr_m = 0;
            in_flight = 0;
            clear_next = 0;
            q.delete();
            gseen = '0;
        end else begin
            if (clear_next) begin
                in_flight = 0;
                clear_next = 0;
            end
            exp_g = '0;
            if (!in_flight) begin
                for (int k = 0; k < N; k++) begin
                    j = (ptr_m + k) % N;
                    if (req[j]) begin
                        exp_g = N'(1) << j;
                        w = j;
                        break;
                    end
                end
            end
            chk("gnt", 32'(gnt), 32'(exp_g));
            chk("busy", 32'(busy), 32'(in_flight));
            gseen = exp_g;
            if (exp_g != '0) begin
                q.push_back('{id: 2'(w), res: ref_ext(imm[w*8 +: 8], mode[w*2 +: 2]), due: cyc + 2});
                in_flight = 1;
                ptr_m = (w + 1) % N;
            end
            if (in_flight && rsp_valid && rsp_ready) clear_next = 1;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (reset) begin
            holding = 0;
        end else if (rsp_valid) begin
            if (holding) begin
                chk("hold_id", 32'(rsp_id), 32'(held_id));
                chk("hold_result", 32'(result), 32'(held_res));
            end else if (q.size() == 0) begin
                chk("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("result", 32'(result), 32'(e.res));
                chk("latency", cyc, e.due);
                held_id = e.id;
                held_res = e.res;
            end
            holding = !rsp_ready;
        end else begin
            if (holding) begin
                chk("valid_dropped", 32'(rsp_valid), 32'd1);
                holding = 0;
            end
            if (q.size() > 0 && cyc > q[0].due) begin
                chk("rsp_timeout", 32'(rsp_valid), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input logic [7:0] v, input logic [1:0] m);
        bit g;
        g = 0;
        req[id] = 1'b1;
        imm[id*8 +: 8] = v;
        mode[id*2 +: 2] = m;
        for (int t = 0; t < 30 && !g; t++) begin
            tick();
            g = gseen[id];
        end
        chk("grant_seen", 32'(g), 32'd1);
        req[id] = 1'b0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (!busy && !rsp_valid) break;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit g;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        reset = 1'b0;
        tick();

        send(0, 8'hFF, 2'b00);
        send(0, 8'h00, 2'b00);
        send(1, 8'h80, 2'b01);
        send(1, 8'h12, 2'b10);
        send(1, 8'h7F, 2'b11);
        send(1, 8'h80, 2'b00);

        // Both requesters held high: responses must alternate every 3 cycles.
        imm = {8'h02, 8'h01};
        mode = '0;
        req = 2'b11;
        repeat (12) tick();
        req = '0;
        repeat (4) tick();

        // Back-pressure with a continuing request behind it.
        rsp_ready = 1'b0;
        imm[7:0] = 8'h5A;
        mode[1:0] = 2'b01;
        req = 2'b01;
        repeat (8) tick();
        rsp_ready = 1'b1;
        repeat (8) tick();
        req = '0;
        repeat (4) tick();

        // Reset while requester 1's transaction is in EXTEND.
        imm[15:8] = 8'hC3;
        mode = '0;
        req = 2'b10;
        g = 0;
        for (int t = 0; t < 30 && !g; t++) begin
            tick();
            g = gseen[1];
        end
        chk("grant_r1", 32'(g), 32'd1);
        reset = 1'b1;
        req = '0;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        req = 2'b11;
        @(negedge clk);
        chk("post_rst_gnt", 32'(gnt), 32'b01);
        tick();
        req = '0;
        repeat (10) tick();

        // Randomized traffic with random back-pressure and abandoned requests.
        for (int c = 0; c < 600; c++) begin
            rsp_ready = $urandom_range(0, 9) < 7;
            for (int i = 0; i < N; i++) begin
                if (gseen[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    imm[i*8 +: 8] = 8'($urandom);
                    mode[i*2 +: 2] = 2'($urandom);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        imm[i*8 +: 8] = 8'($urandom);
                        mode[i*2 +: 2] = 2'($urandom);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
            end
            tick();
        end
        req = '0;
        rsp_ready = 1'b1;
        repeat (10) tick();
        chk("drain", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_arbiter.md
# imm_arbiter

Round-robin arbiter and sequencer that shares one `sign_extender` (8→16) immediate unit among up to four requesters, for example decode-stage immediates and branch-offset generation in the 16-bit datapath. It accepts one 8-bit immediate per transaction with an extension mode and produces a registered 16-bit result. The response is tagged with the requester ID and held under back-pressure until consumed.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2–4.
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: asynchronous, active-high.
- `req`  in  NREQ: per-requester request. Hold high, with `imm`/`mode` stable, until granted.
- `imm`  in  NREQ*8: immediates. Requester i uses `[i*8 +: 8]`.
- `mode`  in  NREQ*2: extension mode. Requester i uses `[i*2 +: 2]`.
- `gnt`  out  NREQ: one-hot grant, combinational, asserted only in IDLE.
- `rsp_valid`  out  1: result valid.
- `rsp_ready`  in  1: consumer accepts the result.
- `rsp_id`  out  2: index of the requester that owns `result`.
- `result`  out  16: extended immediate.
- `busy`  out  1: high whenever state ≠ IDLE.

## Operation
- Modes:
  - 00 → sign-extend through `sign_extender`.
  - 01 → zero-extend, `{8'h00, imm}`.
  - 10 → upper, `{imm, 8'h00}`.
  - 11 → reserved, treated as 00.
- FSM states are IDLE, EXTEND and RESP.
  - IDLE:
    - If any `req` is high, `gnt` selects one requester by round-robin.
    - On the clock edge, latch index, imm and mode, then go to EXTEND.
    - If no `req` is high, stay in IDLE.
  - EXTEND:
    - Drive the latched imm into `sign_extender` and apply the mode mux.
    - Register `result` and `rsp_id`, set `rsp_valid`=1, then go to RESP.
  - RESP:
    - Hold `rsp_valid`, `result` and `rsp_id` while `rsp_ready`=0.
    - At the edge where `rsp_ready`=1: `rsp_valid`→0 and state→IDLE. `result` and `rsp_id` keep their last values.
- Round-robin:
  - The pointer `ptr` names the highest-priority requester.
  - Search order is `ptr`, `ptr`+1, … modulo NREQ.
  - On each grant, `ptr` ← granted index + 1, mod NREQ.
- Requester indices ≥ NREQ never exist. `rsp_id` upper bits are 0 when NREQ=2.
- A grant is a completed handshake: the requester may change `req`/`imm` in the following cycle.

## Timing
- Reset values:
  - state IDLE, `ptr` 0.
  - `gnt` 0 (no `req`), `rsp_valid` 0, `rsp_id` 0, `result` 16'h0000, `busy` 0.
- Latency:
  - Request accepted at edge k (`gnt` high in the preceding cycle).
  - `rsp_valid`/`result` visible after edge k+1.
  - If `rsp_ready`=1, state returns to IDLE at edge k+2.
- Peak throughput is one transaction per 3 cycles.
- `gnt` is combinational from `req`, `ptr` and state. It is 0 in EXTEND and RESP even if `req` is high.
- Simultaneous requests from reset: the lowest index wins first, then rotation proceeds.
- A requester dropping `req` before being granted is legal. Nothing is latched for it.
- `rsp_ready` is ignored outside RESP.
- Reset mid-transaction returns all outputs and `ptr` to their reset values immediately. The in-flight transaction is discarded with no response, and the requester must re-issue.
- `imm` and `mode` are sampled only at the grant edge. Later changes do not affect `result`.

## Structure
- Package `imm_pkg` holds:
  - Mode constants: `MODE_SEXT`=2'b00, `MODE_ZEXT`=2'b01, `MODE_UPPER`=2'b10, `MODE_RSVD`=2'b11.
  - State encoding: IDLE, EXTEND, RESP.
  - Width constants `IMM_W`=8 and `WORD_W`=16.
- Instantiate the existing `sign_extender` once as the only sub-module.
- Round-robin selection is a combinational function inside `imm_arbiter`. It gets no separate module.

## Test plan
- Reset: assert `reset`, drive `req`=0 → `gnt`=0, `rsp_valid`=0, `result`=16'h0000, `busy`=0.
- Sign-extend: `req`=01, imm0=8'hFF, mode0=00, `rsp_ready`=1 → `gnt`=01, then one cycle later `rsp_valid`=1, `result`=16'hFFFF, `rsp_id`=0. Repeat with imm0=8'h00 → 16'h0000.
- Modes on requester 1, each expected result checked:
  - 8'h80 with mode 01 → 16'h0080.
  - 8'h12 with mode 10 → 16'h1200.
  - 8'h7F with mode 11 → 16'h007F.
  - 8'h80 with mode 00 → 16'hFF80.
- Fairness: `req`=11 held continuously, imm0=8'h01, imm1=8'h02 → responses alternate `rsp_id` 0,1,0,1 with results 16'h0001/16'h0002, one response every 3 cycles.
- Back-pressure: hold `rsp_ready`=0 for 4 cycles in RESP with `req`=01 → `rsp_valid`, `result` and `rsp_id` stable and `gnt`=0 throughout. After `rsp_ready`=1, IDLE is reached and the next grant follows.
- Reset in EXTEND: grant requester 1, assert `reset` during EXTEND → outputs return to reset values at once and no `rsp_valid` appears. After release with `req`=11, requester 0 is granted first.
